health_bar_render: RTL and testbench

HEALTH_BAR_RENDER -- requirements
Module: health_bar_render

---
 rtl/health_pkg.sv | 37 +++
 rtl/health_bar_render_if.sv | 10 +
 rtl/health_track.sv | 47 ++++
 rtl/health_bar_render.sv | 127 ++++++++++++
 tb/tb_health_bar_render.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/health_pkg.sv
// Shared constants, colour indices and pixel helpers for the health-bar renderer.
// Both the top level and the per-player tracker import this package.
package health_pkg;

   localparam int BAR_W      = 144;
   localparam int BAR_H      = 12;
   localparam int HEALTH_MAX = 144;

   localparam logic [3:0] FLASH_LOAD = 4'd8;
   localparam logic [1:0] BMP_TEXT   = 2'b01;

   typedef enum logic [2:0] {
      COL_NONE   = 3'd0,
      COL_TEXT   = 3'd1,
      COL_FILL   = 3'd2,
      COL_EMPTY  = 3'd3,
      COL_DAMAGE = 3'd4
   } color_e;

   function automatic logic [7:0] clamp_health(input logic [7:0] h);
      return (h > 8'(HEALTH_MAX)) ? 8'(HEALTH_MAX) : h;
   endfunction

   // Text flashes in the damage colour while bit 1 of the flash counter is set.
   function automatic color_e pixel_color(input logic       text,
                                          input logic       flash_bit,
                                          input logic [7:0] p,
                                          input logic [7:0] target,
                                          input logic [7:0] disp);
      if (text && flash_bit) return COL_DAMAGE;
      if (text)              return COL_TEXT;
      if (p < target)        return COL_FILL;
      if (p < disp)          return COL_DAMAGE;
      return COL_EMPTY;
   endfunction

endpackage

// File: rtl/health_bar_render_if.sv
// Pixel bus between the video scanner (master) and the health-bar renderer (slave).
interface health_bar_render_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic [2:0] bar_color;
   logic       bar_on;

   modport master (output DrawX, output DrawY, input bar_color, input bar_on);
   modport slave  (input DrawX, input DrawY, output bar_color, output bar_on);
endinterface

// File: rtl/health_track.sv
// Per-player health state: displayed (draining) health, previous target and
// the hit-flash counter, all advanced once per frame tick.
module health_track
   import health_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       i_frame_tick,
   input  logic [7:0] i_target,
   output logic [7:0] o_target,
   output logic [7:0] o_disp,
   output logic [3:0] o_flash_cnt
);

   logic [7:0] w_target;
   logic [7:0] r_disp;
   logic [7:0] r_prev_target;
   logic [3:0] r_flash_cnt;

   assign w_target = clamp_health(i_target);

   // Drain by one per frame on damage, snap up immediately on heal.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_disp        <= 8'(HEALTH_MAX);
         r_prev_target <= 8'(HEALTH_MAX);
         r_flash_cnt   <= 4'd0;
      end else if (i_frame_tick) begin
         if (r_disp > w_target) begin
            r_disp <= r_disp - 8'd1;
         end else if (r_disp < w_target) begin
            r_disp <= w_target;
         end
         r_prev_target <= w_target;
         if (w_target < r_prev_target) begin
            r_flash_cnt <= FLASH_LOAD;
         end else if (r_flash_cnt != 4'd0) begin
            r_flash_cnt <= r_flash_cnt - 4'd1;
         end
      end
   end

   assign o_target    = w_target;
   assign o_disp      = r_disp;
   assign o_flash_cnt = r_flash_cnt;

endmodule

// File: rtl/health_bar_render.sv
// Renders the dive (left-to-right) and kick (mirrored) health bars with a
// draining damage segment and flashing text; colour is registered one cycle.
module health_bar_render
   import health_pkg::*;
#(
   parameter int DIVE_X0 = 16,
   parameter int KICK_X0 = 480,
   parameter int BAR_Y0  = 16
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic [7:0] dive_health,
   input  logic [7:0] kick_health,
   input  logic [1:0] dive_health_bar [BAR_H][BAR_W],
   input  logic [1:0] kick_health_bar [BAR_H][BAR_W],
   health_bar_render_if.slave pix
);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_sync3;
   logic [1:0] r_arm_cnt;
   logic       w_frame_tick;

   // The arm counter masks the edge detector until the synchroniser has
   // filled, so a frame_clk already high at reset release is not a tick.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync3   <= 1'b0;
         r_arm_cnt <= 2'd0;
      end else begin
         r_sync1 <= frame_clk;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         if (r_arm_cnt != 2'd3) begin
            r_arm_cnt <= r_arm_cnt + 2'd1;
         end
      end
   end

   assign w_frame_tick = r_sync2 & ~r_sync3 & (r_arm_cnt == 2'd3);

   logic [10:0] w_dy;
   logic        w_row_ok;
   logic [3:0]  w_row;

   assign w_dy     = {1'b0, pix.DrawY} - 11'(BAR_Y0);
   assign w_row_ok = (w_dy < 11'(BAR_H));
   assign w_row    = w_dy[3:0];

   logic [7:0]  w_health   [2];
   logic [10:0] w_dx       [2];
   logic        w_in_bar   [2];
   logic [7:0]  w_col      [2];
   logic [7:0]  w_pos      [2];
   logic        w_text     [2];
   logic [7:0]  w_target   [2];
   logic [7:0]  w_disp     [2];
   logic [3:0]  w_flash    [2];
   color_e      w_color    [2];

   assign w_health[0] = dive_health;
   assign w_health[1] = kick_health;
   assign w_text[0]   = (dive_health_bar[w_row][w_col[0]] == BMP_TEXT);
   assign w_text[1]   = (kick_health_bar[w_row][w_col[1]] == BMP_TEXT);

   // Index 0 is the dive player, index 1 the kick player (mirrored fill).
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_player
         localparam logic [10:0] L_X0 = (gi == 0) ? 11'(DIVE_X0) : 11'(KICK_X0);

         assign w_dx[gi]     = {1'b0, pix.DrawX} - L_X0;
         assign w_in_bar[gi] = (w_dx[gi] < 11'(BAR_W)) && w_row_ok;
         assign w_col[gi]    = w_dx[gi][7:0];
         assign w_pos[gi]    = (gi == 0) ? w_col[gi] : (8'(BAR_W - 1) - w_col[gi]);

         health_track u_track (
            .Clk         (Clk),
            .Reset_n     (Reset_n),
            .i_frame_tick(w_frame_tick),
            .i_target    (w_health[gi]),
            .o_target    (w_target[gi]),
            .o_disp      (w_disp[gi]),
            .o_flash_cnt (w_flash[gi])
         );

         assign w_color[gi] = pixel_color(w_text[gi], w_flash[gi][1], w_pos[gi],
                                          w_target[gi], w_disp[gi]);
      end
   endgenerate

   color_e w_color_next;
   logic   w_on_next;
   color_e r_bar_color;
   logic   r_bar_on;

   // Dive takes priority should the two bars ever overlap.
   always_comb begin
      w_color_next = COL_NONE;
      w_on_next    = 1'b0;
      if (w_in_bar[0]) begin
         w_color_next = w_color[0];
         w_on_next    = 1'b1;
      end else if (w_in_bar[1]) begin
         w_color_next = w_color[1];
         w_on_next    = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_bar_color <= COL_NONE;
         r_bar_on    <= 1'b0;
      end else begin
         r_bar_color <= w_color_next;
         r_bar_on    <= w_on_next;
      end
   end

   assign pix.bar_color = r_bar_color;
   assign pix.bar_on    = r_bar_on;

endmodule

// File: tb/tb_health_bar_render.sv
// Directed bench for health_bar_render: scans bar pixels after controlled
// frame ticks and compares the registered colour with hand-derived values.
module tb_health_bar_render;

   logic       Clk       = 1'b0;
   logic       Reset_n   = 1'b0;
   logic       frame_clk = 1'b0;
   logic [7:0] dive_health = 8'd144;
   logic [7:0] kick_health = 8'd144;
   logic [1:0] dive_bmp [0:11][0:143];
   logic [1:0] kick_bmp [0:11][0:143];

   int checks   = 0;
   int failures = 0;

   health_bar_render_if pix ();

   health_bar_render dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .frame_clk      (frame_clk),
      .dive_health    (dive_health),
      .kick_health    (kick_health),
      .dive_health_bar(dive_bmp),
      .kick_health_bar(kick_bmp),
      .pix            (pix)
   );

   always #5 Clk = ~Clk;

   // Present a pixel on a falling edge; the registered result is read 1 ns after the next rising edge.
   task automatic drive_pix(input int x, input int y);
      @(negedge Clk);
      pix.DrawX = 10'(x);
      pix.DrawY = 10'(y);
      @(posedge Clk);
      #1;
   endtask

   task automatic frame_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         frame_clk = 1'b1;
         repeat (3) @(negedge Clk);
         frame_clk = 1'b0;
         repeat (2) @(negedge Clk);
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_reset();
      @(negedge Clk);
      pix.DrawX = 10'd30;
      pix.DrawY = 10'd20;
      Reset_n   = 1'b0;
      #1;
      checks++;
      if (pix.bar_color !== 3'd0) begin
         failures++;
         $display("FAIL reset_color got=%0d exp=0", pix.bar_color);
      end
      checks++;
      if (pix.bar_on !== 1'b0) begin
         failures++;
         $display("FAIL reset_on got=%0d exp=0", pix.bar_on);
      end
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_full_bar();
      logic [2:0] exp;
      for (int c = 0; c < 144; c++) begin
         drive_pix(16 + c, 21);
         exp = (c >= 10 && c <= 13) ? 3'd1 : 3'd2;
         checks++;
         if (pix.bar_color !== exp || pix.bar_on !== 1'b1) begin
            failures++;
            $display("FAIL full_dive_row5 c=%0d got=%0d/%0d exp=%0d/1", c, pix.bar_color, pix.bar_on, exp);
         end
      end
      // Change to a text pixel; until the next rising edge the old fill colour must remain.
      @(negedge Clk);
      pix.DrawX = 10'd26;
      #1;
      checks++;
      if (pix.bar_color !== 3'd2) begin
         failures++;
         $display("FAIL latency_before got=%0d exp=2", pix.bar_color);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (pix.bar_color !== 3'd1) begin
         failures++;
         $display("FAIL latency_after got=%0d exp=1", pix.bar_color);
      end
      drive_pix(500, 19);
      checks++;
      if (pix.bar_color !== 3'd1) begin
         failures++;
         $display("FAIL kick_text got=%0d exp=1", pix.bar_color);
      end
      drive_pix(600, 16);
      checks++;
      if (pix.bar_color !== 3'd2) begin
         failures++;
         $display("FAIL kick_full got=%0d exp=2", pix.bar_color);
      end
   endtask

   task automatic test_damage();
      logic [3:0] flash_exp;
      int         disp_exp;
      logic [2:0] exp;
      do_reset();
      dive_health = 8'd100;
      for (int k = 1; k <= 44; k++) begin
         frame_ticks(1);
         disp_exp  = 144 - k;
         flash_exp = (k < 9) ? 4'(9 - k) : 4'd0;
         if (k <= 10) begin
            drive_pix(26, 21);
            exp = flash_exp[1] ? 3'd4 : 3'd1;
            checks++;
            if (pix.bar_color !== exp) begin
               failures++;
               $display("FAIL flash_text tick=%0d got=%0d exp=%0d", k, pix.bar_color, exp);
            end
         end
         drive_pix(16 + disp_exp, 16);
         checks++;
         if (pix.bar_color !== 3'd3) begin
            failures++;
            $display("FAIL drain_edge tick=%0d p=%0d got=%0d exp=3", k, disp_exp, pix.bar_color);
         end
         drive_pix(16 + disp_exp - 1, 16);
         exp = (disp_exp - 1 >= 100) ? 3'd4 : 3'd2;
         checks++;
         if (pix.bar_color !== exp) begin
            failures++;
            $display("FAIL drain_inner tick=%0d p=%0d got=%0d exp=%0d", k, disp_exp - 1, pix.bar_color, exp);
         end
      end
      frame_ticks(2);
      drive_pix(116, 16);
      checks++;
      if (pix.bar_color !== 3'd3) begin
         failures++;
         $display("FAIL drain_hold got=%0d exp=3", pix.bar_color);
      end
   endtask

   task automatic test_kick();
      logic [2:0] exp;
      do_reset();
      dive_health = 8'd144;
      kick_health = 8'd50;
      frame_ticks(1);
      drive_pix(480, 16);
      checks++;
      if (pix.bar_color !== 3'd3) begin
         failures++;
         $display("FAIL kick_first c=0 got=%0d exp=3", pix.bar_color);
      end
      drive_pix(481, 16);
      checks++;
      if (pix.bar_color !== 3'd4) begin
         failures++;
         $display("FAIL kick_first c=1 got=%0d exp=4", pix.bar_color);
      end
      drive_pix(574, 16);
      checks++;
      if (pix.bar_color !== 3'd2) begin
         failures++;
         $display("FAIL kick_first c=94 got=%0d exp=2", pix.bar_color);
      end
      frame_ticks(93);
      for (int c = 0; c < 144; c++) begin
         drive_pix(480 + c, 16);
         exp = (c >= 94) ? 3'd2 : 3'd3;
         checks++;
         if (pix.bar_color !== exp) begin
            failures++;
            $display("FAIL kick_drained c=%0d got=%0d exp=%0d", c, pix.bar_color, exp);
         end
      end
      kick_health = 8'd144;
   endtask

   task automatic test_clamp_and_zero();
      do_reset();
      dive_health = 8'd200;
      frame_ticks(1);
      drive_pix(159, 16);
      checks++;
      if (pix.bar_color !== 3'd2) begin
         failures++;
         $display("FAIL clamp_fill got=%0d exp=2", pix.bar_color);
      end
      dive_health = 8'd144;
      frame_ticks(2);
      drive_pix(26, 21);
      checks++;
      if (pix.bar_color !== 3'd1) begin
         failures++;
         $display("FAIL clamp_no_flash got=%0d exp=1", pix.bar_color);
      end
      dive_health = 8'd0;
      frame_ticks(146);
      for (int i = 0; i < 3; i++) begin
         drive_pix(16 + i * 71, 16);
         checks++;
         if (pix.bar_color !== 3'd3) begin
            failures++;
            $display("FAIL zero_drained p=%0d got=%0d exp=3", i * 71, pix.bar_color);
         end
      end
      frame_ticks(3);
      drive_pix(16, 16);
      checks++;
      if (pix.bar_color !== 3'd3) begin
         failures++;
         $display("FAIL zero_hold got=%0d exp=3", pix.bar_color);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] seq_exp [6];
      seq_exp = '{3'd1, 3'd4, 3'd4, 3'd1, 3'd1, 3'd4};
      do_reset();
      dive_health = 8'd100;
      frame_ticks(3);
      dive_health = 8'd90;
      // Flash should read 8,7,6,5,4,3 after the reload tick.
      for (int k = 0; k < 6; k++) begin
         frame_ticks(1);
         drive_pix(26, 21);
         checks++;
         if (pix.bar_color !== seq_exp[k]) begin
            failures++;
            $display("FAIL rehit_flash step=%0d got=%0d exp=%0d", k, pix.bar_color, seq_exp[k]);
         end
      end
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      checks++;
      if (pix.bar_color !== 3'd0 || pix.bar_on !== 1'b0) begin
         failures++;
         $display("FAIL midreset_async got=%0d/%0d exp=0/0", pix.bar_color, pix.bar_on);
      end
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (4) @(negedge Clk);
      drive_pix(159, 16);
      checks++;
      if (pix.bar_color !== 3'd4) begin
         failures++;
         $display("FAIL midreset_disp p=143 got=%0d exp=4", pix.bar_color);
      end
   endtask

   task automatic test_reset_frame_high();
      @(negedge Clk);
      frame_clk = 1'b1;
      Reset_n   = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (6) @(negedge Clk);
      drive_pix(159, 16);
      checks++;
      if (pix.bar_color !== 3'd4) begin
         failures++;
         $display("FAIL spurious_tick got=%0d exp=4", pix.bar_color);
      end
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      drive_pix(159, 16);
      checks++;
      if (pix.bar_color !== 3'd4) begin
         failures++;
         $display("FAIL falling_no_tick got=%0d exp=4", pix.bar_color);
      end
      frame_ticks(1);
      drive_pix(159, 16);
      checks++;
      if (pix.bar_color !== 3'd3) begin
         failures++;
         $display("FAIL tick_after_release got=%0d exp=3", pix.bar_color);
      end
   endtask

   task automatic test_outside();
      int xs [6];
      int ys [6];
      xs = '{160, 20, 15, 479, 624, 100};
      ys = '{20, 28, 20, 20, 20, 15};
      for (int i = 0; i < 6; i++) begin
         drive_pix(xs[i], ys[i]);
         checks++;
         if (pix.bar_color !== 3'd0 || pix.bar_on !== 1'b0) begin
            failures++;
            $display("FAIL outside x=%0d y=%0d got=%0d/%0d exp=0/0", xs[i], ys[i], pix.bar_color, pix.bar_on);
         end
      end
   endtask

   initial begin
      for (int r = 0; r < 12; r++) begin
         for (int c = 0; c < 144; c++) begin
            dive_bmp[r][c] = 2'b11;
            kick_bmp[r][c] = 2'b11;
         end
      end
      for (int c = 10; c <= 13; c++) dive_bmp[5][c] = 2'b01;
      kick_bmp[3][20] = 2'b01;
      kick_bmp[3][21] = 2'b01;
      pix.DrawX = 10'd0;
      pix.DrawY = 10'd0;

      test_reset();
      test_full_bar();
      test_damage();
      test_kick();
      test_clamp_and_zero();
      test_back_to_back();
      test_reset_frame_high();
      test_outside();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
